// File: rtl/mem_access_arbiter_if.sv
// Bundle of the two requester ports and the RAM port of the memory access arbiter.
// The arbiter uses the master modport; the requester/RAM environment uses slave.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_done;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_done;
    logic [DATA_W-1:0] req1_rdata;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_rdata,
        output req0_ready, req0_done, req0_rdata,
        output req1_ready, req1_done, req1_rdata,
        output ram_we, ram_re, ram_addr, ram_wdata,
        output busy
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_rdata,
        input  req0_ready, req0_done, req0_rdata,
        input  req1_ready, req1_done, req1_rdata,
        input  ram_we, ram_re, ram_addr, ram_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between two requesters.
// Each accepted transaction runs IDLE -> ACCESS -> RESP and returns a one-cycle done pulse.
module mem_access_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    mem_access_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant_any;
    logic              grant_sel;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant_sel = ~last_grant;
        else
            grant_sel = bus.req1_valid;
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_re     = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_wdata  = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    bus.req0_ready = ~grant_sel;
                    bus.req1_ready = grant_sel;
                    state_nxt      = ACCESS;
                end
            end
            ACCESS: begin
                // Strobes are gated by clear so a write caught by reset never lands.
                bus.ram_addr = lat_addr;
                if (lat_we) begin
                    bus.ram_we    = ~clear;
                    bus.ram_wdata = lat_wdata;
                end else begin
                    bus.ram_re = ~clear;
                end
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (clear)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            lat_we         <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            bus.req0_done  <= 1'b0;
            bus.req1_done  <= 1'b0;
            bus.req0_rdata <= '0;
            bus.req1_rdata <= '0;
        end else begin
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;
            if (state == IDLE && grant_any) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                lat_we     <= grant_sel ? bus.req1_we    : bus.req0_we;
                lat_addr   <= grant_sel ? bus.req1_addr  : bus.req0_addr;
                lat_wdata  <= grant_sel ? bus.req1_wdata : bus.req0_wdata;
            end
            // RAM read data is valid during RESP, one cycle after the read strobe.
            if (state == RESP) begin
                if (owner) begin
                    bus.req1_done <= 1'b1;
                    if (!lat_we)
                        bus.req1_rdata <= bus.ram_rdata;
                end else begin
                    bus.req0_done <= 1'b1;
                    if (!lat_we)
                        bus.req0_rdata <= bus.ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration, timing and RAM contents.
module tb_mem_access_arbiter;

    logic clock;
    logic clear;
    int   total;
    int   bad;

    mem_access_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: synchronous write, read data registered one cycle after ram_re.
    logic [31:0] mem [0:511];
    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clock) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re)
            bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        @(negedge clock);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clock);
        bd_we   = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [8:0] a, input logic [31:0] d);
        if (n == 0) begin
            bus.req0_valid = v;
            bus.req0_we    = we;
            bus.req0_addr  = a;
            bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v;
            bus.req1_we    = we;
            bus.req1_addr  = a;
            bus.req1_wdata = d;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (2) @(negedge clock);
        #1;
        total++;
        if ({bus.busy, bus.req0_done, bus.req1_done, bus.ram_we, bus.ram_re,
             bus.req0_ready, bus.req1_ready} !== 7'b0)
            begin bad++; $display("FAIL reset_ctrl: got %b want 0000000",
                {bus.busy, bus.req0_done, bus.req1_done, bus.ram_we, bus.ram_re,
                 bus.req0_ready, bus.req1_ready}); end
        total++;
        if ({bus.req0_rdata, bus.req1_rdata} !== 64'h0)
            begin bad++; $display("FAIL reset_rdata: got %h %h want 0 0",
                bus.req0_rdata, bus.req1_rdata); end
        clear = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 9'h005, 32'hDEADBEEF);
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
            begin bad++; $display("FAIL wr_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        total++;
        if ({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata, bus.busy} !== {1'b1, 1'b0, 9'h005, 32'hDEADBEEF, 1'b1})
            begin bad++; $display("FAIL wr_access: got we=%b re=%b a=%h d=%h busy=%b want 1 0 005 deadbeef 1",
                bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata, bus.busy); end
        @(negedge clock);
        #1;
        total++;
        if ({bus.ram_we, bus.ram_re, bus.busy, bus.req0_done} !== 4'b0010)
            begin bad++; $display("FAIL wr_resp: got %b want 0010",
                {bus.ram_we, bus.ram_re, bus.busy, bus.req0_done}); end
        @(negedge clock);
        #1;
        total++;
        if ({bus.ram_we, bus.busy, bus.req0_done, bus.req1_done} !== 4'b0010)
            begin bad++; $display("FAIL wr_done: got %b want 0010",
                {bus.ram_we, bus.busy, bus.req0_done, bus.req1_done}); end
        set_req(0, 1'b1, 1'b0, 9'h005, 32'h0);
        #1;
        total++;
        if (bus.req0_ready !== 1'b1)
            begin bad++; $display("FAIL rd_ready_in_done_cycle: got %b want 1", bus.req0_ready); end
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        total++;
        if ({bus.ram_we, bus.ram_re, bus.ram_addr} !== {1'b0, 1'b1, 9'h005})
            begin bad++; $display("FAIL rd_access: got we=%b re=%b a=%h want 0 1 005",
                bus.ram_we, bus.ram_re, bus.ram_addr); end
        @(negedge clock);
        #1;
        total++;
        if (bus.req0_done !== 1'b0)
            begin bad++; $display("FAIL rd_early_done: got %b want 0", bus.req0_done); end
        @(negedge clock);
        #1;
        total++;
        if ({bus.req0_done, bus.req0_rdata} !== {1'b1, 32'hDEADBEEF})
            begin bad++; $display("FAIL rd_done_data: got %b %h want 1 deadbeef",
                bus.req0_done, bus.req0_rdata); end
        @(negedge clock);
        #1;
        total++;
        if (bus.req0_done !== 1'b0)
            begin bad++; $display("FAIL rd_done_width: got %b want 0", bus.req0_done); end
    endtask

    task automatic test_isolation();
        preload(9'h1FF, 32'h12345678);
        @(negedge clock);
        set_req(1, 1'b1, 1'b0, 9'h1FF, 32'h0);
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
            begin bad++; $display("FAIL iso_ready: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k == 1) set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
            #1;
            total++;
            if ({bus.req0_done, bus.req1_done} !== {1'b0, (k == 3)})
                begin bad++; $display("FAIL iso_done k=%0d: got %b want %b", k,
                    {bus.req0_done, bus.req1_done}, {1'b0, (k == 3)}); end
        end
        total++;
        if ({bus.req1_rdata, bus.req0_rdata} !== {32'h12345678, 32'hDEADBEEF})
            begin bad++; $display("FAIL iso_rdata: got %h %h want 12345678 deadbeef",
                bus.req1_rdata, bus.req0_rdata); end
    endtask

    task automatic test_tie();
        logic [4:0] exp;
        logic [1:0] er;
        logic [1:0] ed;
        preload(9'h010, 32'h11110010);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        set_req(0, 1'b1, 1'b0, 9'h010, 32'h0);
        set_req(1, 1'b1, 1'b0, 9'h1FF, 32'h0);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clock);
            if (k == 12) begin
                set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
                set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
            end
            #1;
            er = 2'b00;
            ed = 2'b00;
            if (k % 3 == 0 && k < 12) er = ((k / 3) % 2 == 0) ? 2'b10 : 2'b01;
            if (k % 3 == 0 && k > 0)  ed = (((k / 3) - 1) % 2 == 0) ? 2'b10 : 2'b01;
            exp = {er, ed, (k % 3 != 0)};
            total++;
            if ({bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done, bus.busy} !== exp)
                begin bad++; $display("FAIL tie k=%0d rdy/done/busy: got %b want %b", k,
                    {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done, bus.busy}, exp); end
        end
        total++;
        if ({bus.req0_rdata, bus.req1_rdata} !== {32'h11110010, 32'h12345678})
            begin bad++; $display("FAIL tie_rdata: got %h %h want 11110010 12345678",
                bus.req0_rdata, bus.req1_rdata); end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp;
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 9'h030, 32'h0BADF00D);
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
            begin bad++; $display("FAIL bp_ready0: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) begin
                set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
                set_req(1, 1'b1, 1'b0, 9'h010, 32'h0);
            end
            if (k == 4) set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
            #1;
            exp = {1'b0, (k == 3), (k != 3 && k != 6), (k == 3), (k == 6)};
            total++;
            if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.req0_done, bus.req1_done} !== exp)
                begin bad++; $display("FAIL bp k=%0d rdy/busy/done: got %b want %b", k,
                    {bus.req0_ready, bus.req1_ready, bus.busy, bus.req0_done, bus.req1_done}, exp); end
        end
        total++;
        if (bus.req1_rdata !== 32'h11110010)
            begin bad++; $display("FAIL bp_rdata1: got %h want 11110010", bus.req1_rdata); end
    endtask

    task automatic test_reset_mid_write();
        logic [3:0] exp;
        preload(9'h020, 32'h5A5A0020);
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D);
        #1;
        total++;
        if (bus.req0_ready !== 1'b1)
            begin bad++; $display("FAIL rmw_ready: got %b want 1", bus.req0_ready); end
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        total++;
        if (bus.ram_we !== 1'b1)
            begin bad++; $display("FAIL rmw_access: ram_we got %b want 1", bus.ram_we); end
        clear = 1'b1;
        #1;
        total++;
        if ({bus.ram_we, bus.ram_re} !== 2'b00)
            begin bad++; $display("FAIL rmw_suppress: got %b want 00", {bus.ram_we, bus.ram_re}); end
        @(negedge clock);
        clear = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.req0_done, bus.req1_done, bus.req0_rdata, bus.req1_rdata} !== 67'h0)
            begin bad++; $display("FAIL rmw_after_reset: busy=%b done=%b%b rdata=%h %h want all 0",
                bus.busy, bus.req0_done, bus.req1_done, bus.req0_rdata, bus.req1_rdata); end
        set_req(0, 1'b1, 1'b0, 9'h020, 32'h0);
        set_req(1, 1'b1, 1'b0, 9'h010, 32'h0);
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
            begin bad++; $display("FAIL rmw_tie: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
            if (k == 4) set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
            #1;
            exp = {1'b0, (k == 3), (k == 3), (k == 6)};
            total++;
            if ({bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done} !== exp)
                begin bad++; $display("FAIL rmw k=%0d rdy/done: got %b want %b", k,
                    {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done}, exp); end
        end
        total++;
        if (bus.req0_rdata !== 32'h5A5A0020)
            begin bad++; $display("FAIL rmw_not_written: got %h want 5a5a0020", bus.req0_rdata); end
    endtask

    task automatic test_write_keeps_rdata();
        preload(9'h003, 32'hAAAA5555);
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 9'h003, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1 || k == 4) set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
            if (k == 3) set_req(0, 1'b1, 1'b1, 9'h003, 32'h0);
            #1;
            if (k == 3 || k == 6) begin
                total++;
                if ({bus.req0_done, bus.req0_rdata} !== {1'b1, 32'hAAAA5555})
                    begin bad++; $display("FAIL wkr k=%0d done/rdata: got %b %h want 1 aaaa5555",
                        k, bus.req0_done, bus.req0_rdata); end
            end
        end
        total++;
        if (mem[3] !== 32'h0)
            begin bad++; $display("FAIL wkr_mem: got %h want 0", mem[3]); end
    endtask

    task automatic test_random();
        localparam int NCYC = 600;
        logic [8:0]  atab    [16];
        logic [31:0] ref_mem [16];
        logic [31:0] exp_rd  [2];
        logic        pend    [2];
        logic        p_we    [2];
        int          p_idx   [2];
        logic [31:0] p_wdata [2];
        int          acc_k;
        int          nacc;
        logic        mlast, c_owner, c_we, g, free;
        int          c_idx;
        logic [31:0] c_wdata, c_rd;
        logic [1:0]  exp_rdy, exp_done;
        logic [42:0] exp_ram;

        for (int i = 0; i < 16; i++) begin
            atab[i]    = (i == 15) ? 9'h1FF : 9'(i * 33);
            ref_mem[i] = $urandom;
            preload(atab[i], ref_mem[i]);
        end
        for (int n = 0; n < 2; n++) begin
            exp_rd[n] = 32'h0; pend[n] = 1'b0; p_we[n] = 1'b0; p_idx[n] = 0; p_wdata[n] = 32'h0;
        end
        acc_k = -10; nacc = 0; mlast = 1'b1; c_owner = 1'b0; c_we = 1'b0; c_idx = 0;
        c_wdata = 32'h0; c_rd = 32'h0; g = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            if (k > 0) @(negedge clock);
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && k < NCYC - 10 && $urandom_range(0, 2) != 0) begin
                    pend[n]    = 1'b1;
                    p_we[n]    = 1'($urandom_range(0, 1));
                    p_idx[n]   = $urandom_range(0, 15);
                    p_wdata[n] = $urandom;
                end
            end
            set_req(0, pend[0], p_we[0], atab[p_idx[0]], p_wdata[0]);
            set_req(1, pend[1], p_we[1], atab[p_idx[1]], p_wdata[1]);
            #1;
            exp_done = 2'b00;
            if (k == acc_k + 3) begin
                exp_done = c_owner ? 2'b01 : 2'b10;
                if (!c_we) exp_rd[c_owner] = c_rd;
            end
            free    = (k >= acc_k + 3);
            exp_rdy = 2'b00;
            if (free && (pend[0] || pend[1])) begin
                g       = (pend[0] && pend[1]) ? ~mlast : pend[1];
                exp_rdy = g ? 2'b01 : 2'b10;
            end
            exp_ram = 43'h0;
            if (k == acc_k + 1)
                exp_ram = {c_we, ~c_we, atab[c_idx], (c_we ? c_wdata : 32'h0)};
            total++;
            if ({bus.req0_ready, bus.req1_ready} !== exp_rdy)
                begin bad++; $display("FAIL rnd_ready k=%0d: got %b want %b", k,
                    {bus.req0_ready, bus.req1_ready}, exp_rdy); end
            total++;
            if ({bus.req0_done, bus.req1_done, bus.busy} !== {exp_done, ~free})
                begin bad++; $display("FAIL rnd_done_busy k=%0d: got %b want %b", k,
                    {bus.req0_done, bus.req1_done, bus.busy}, {exp_done, ~free}); end
            total++;
            if ({bus.req0_rdata, bus.req1_rdata} !== {exp_rd[0], exp_rd[1]})
                begin bad++; $display("FAIL rnd_rdata k=%0d: got %h %h want %h %h", k,
                    bus.req0_rdata, bus.req1_rdata, exp_rd[0], exp_rd[1]); end
            total++;
            if ({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata} !== exp_ram)
                begin bad++; $display("FAIL rnd_ram k=%0d: got %h want %h", k,
                    {bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata}, exp_ram); end
            if (exp_rdy != 2'b00) begin
                acc_k   = k;
                c_owner = g;
                mlast   = g;
                c_we    = p_we[g];
                c_idx   = p_idx[g];
                c_wdata = p_wdata[g];
                if (c_we) ref_mem[c_idx] = c_wdata;
                else      c_rd = ref_mem[c_idx];
                pend[g] = 1'b0;
                nacc++;
            end
        end
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (4) @(negedge clock);
        total++;
        if (nacc < 50)
            begin bad++; $display("FAIL rnd_accept_count: got %0d want >=50", nacc); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        bd_we = 1'b0;
        bd_addr = 9'h0;
        bd_data = 32'h0;
        test_reset();
        test_write_read();
        test_isolation();
        test_tie();
        test_backpressure();
        test_reset_mid_write();
        test_write_keeps_rdata();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-port arbiter and sequencer for the 512x32 single-port datapath RAM.
- Shares the RAM between requester 0 (CPU MAR/MDR path) and requester 1 (I/O / loader port).
- Issues exactly one RAM read or write per accepted transaction, with round-robin fairness.
- Returns read data and a done pulse to the requester that owns the transaction.

Parameters:
- ADDR_W, 9, RAM address width (2^9 = 512 words).
- DATA_W, 32, data word width.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a transaction pending.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  transaction accepted this cycle (combinational).
- req0_done  out  1  one-cycle completion pulse (registered).
- req0_rdata  out  DATA_W  read result (registered, held until next read completion).
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata: identical to the req0 set, for requester 1.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (clear=1 at an edge): state=IDLE, last_grant=1, owner=0, latched addr/wdata/we=0, reqN_done=0, reqN_rdata=0.
- While clear=1, ram_we and ram_re are forced to 0 combinationally, so a write in flight is suppressed.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Grant selection: only one valid -> that requester. Both valid -> requester != last_grant. Neither valid -> stay in IDLE.
  - reqN_ready=1 for the granted requester only; it is 0 in every other state.
  - On valid&&ready at an edge: latch we/addr/wdata, set owner=N and last_grant=N, go to ACCESS.
- ACCESS (1 cycle):
  - ram_addr = latched addr.
  - Write: ram_we=1, ram_wdata = latched wdata, ram_re=0.
  - Read: ram_re=1, ram_we=0.
  - Always proceeds to RESP.
- RESP (1 cycle):
  - ram_we=0 and ram_re=0.
  - At the exit edge: reqOwner_done<=1 for one cycle.
  - If the transaction was a read, reqOwner_rdata<=ram_rdata. A write leaves rdata unchanged.
  - Next state is IDLE.
- Outside ACCESS, ram_* outputs are 0.
- done is never asserted for the non-owner and never for two cycles in a row from the same transaction.
- Timing:
  - Accept edge T. RAM strobe in cycle T..T+1. done and rdata visible in cycle T+2..T+3.
  - A new request can be accepted at edge T+3, i.e. in the same cycle done is visible.
  - Peak throughput is 1 transaction per 3 cycles.
- Requester rule: valid, we, addr and wdata are held stable until ready. The block does not check for changes after acceptance, because the fields are latched.
- Simultaneous events:
  - A request arriving in ACCESS or RESP waits; no ready is given.
  - Both requesters continuously valid -> grants alternate 0,1,0,1.
- Address wrap: no arithmetic is performed; addr passes through unmodified.
- Reset mid-operation: the in-flight transaction is dropped, no done is issued, and arbitration restarts with requester 0 preferred.

Test Plan:
1. Write then read, req0 only: write addr=0x005 data=0xDEADBEEF, then read 0x005. Required: ram_we high exactly 1 cycle with ram_addr=0x005; second done pulse carries req0_rdata=0xDEADBEEF, 3 cycles after accept.
2. Tie after reset: req0 and req1 both valid, reading 0x010 and 0x1FF. Required: req0 granted first; req1 ready appears at the edge after req0_done is set; grant order 0,1,0,1 while both are held valid.
3. Ownership isolation: req1 reads 0x1FF (RAM model returns 0x12345678). Required: req1_rdata=0x12345678 and req1_done pulses; req0_done and req0_rdata are unchanged.
4. Backpressure: req1 asserts valid during req0's ACCESS. Required: req1_ready=0 through ACCESS and RESP, then ready=1 in the next IDLE; busy=1 for exactly 2 cycles per transaction.
5. Reset mid-write: assert clear during ACCESS of a write to 0x020. Required: ram_we=0 that cycle, no done, rdata=0, state IDLE; a following tie is granted to req0.
6. Write does not disturb rdata: read 0x003 (returns 0xAAAA5555), then write 0x003 with 0x0. Required: write done pulses and req0_rdata stays 0xAAAA5555.
